spi_ram_master: RTL and testbench
=================================

// Module: spi_ram_master
// PURPOSE
//  Host-side transaction controller for the SPI slave + RAM wrapper. Converts one
//  host command (write byte / read byte at 8-bit address) into the two SPI frames
//  the slave/RAM pair expects, drives ss_n/MOSI, captures MISO, returns a response.
//  Sits between the system/test host and the wrapper's MOSI/ss_n/MISO pins, same clk.
// PARAMETERS
//  GAP_CYCLES  1  ss_n-high cycles after every frame (>=1)
//  RD_WAIT     2  ss_n-low, MOSI=0 cycles between RD_DATA word and first MISO bit (>=1)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  synchronous reset, active-high
//  cmd_valid  in   1  host command request
//  cmd_ready  out  1  controller can accept a command (IDLE only)
//  cmd_rw     in   1  0 = write, 1 = read
//  cmd_addr   in   8  RAM address
//  cmd_wdata  in   8  write data (ignored on read)
//  rsp_valid  out  1  one-cycle completion pulse, no backpressure
//  rsp_rdata  out  8  read data, valid with rsp_valid; 8'h00 for writes
//  busy       out  1  high from accept until cmd_ready returns
//  ss_n       out  1  SPI slave select, active-low
//  MOSI       out  1  serial data to wrapper
//  MISO       in   1  serial data from wrapper
// BEHAVIOUR
//  Reset: ss_n=1, MOSI=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, FSM=IDLE.
//  Accept: cmd_valid&&cmd_ready at edge E -> cmd_rw/addr/wdata registered; cmd_ready=0
//   from E+1. Edge E = cycle 0; cycle n = n-th cycle after it.
//  Frame (10-bit word W): 11 cycles ss_n=0; 1st cycle MOSI=W[9] (slave cmd-check bit),
//   next 10 cycles MOSI=W[9..0] MSB first. Then GAP_CYCLES with ss_n=1, MOSI=0.
//  Words: WR_ADDR={2'b00,addr} WR_DATA={2'b01,wdata} RD_ADDR={2'b10,addr}
//   RD_DATA={2'b11,8'h00}.
//  FSM: IDLE -> ADDR_FRM -> GAP1 -> DATA_FRM -> (write) GAP2 -> IDLE
//                                         -> (read) RD_WAIT -> RD_SHIFT -> GAP2 -> IDLE
//  RD_SHIFT: 8 cycles ss_n=0, MOSI=0; MISO sampled at the rising edge ending each
//   cycle, MSB first, into shift reg; ss_n held low through last sample.
//  rsp_valid=1 exactly in first GAP2 cycle; rsp_rdata updated same cycle, held until next rsp.
//  cmd_ready=1 (busy=0) in cycle after last GAP2 cycle; back-to-back cmds never shorten gap.
//  Bit counter 4-bit, counts 0..10 per frame, 0..7 in RD_SHIFT; gap/wait counters sized
//   from params; no wrap beyond terminal count.
//  cmd_valid while busy: ignored, not queued; fields may change freely.
//  rst mid-operation (any state): next edge forces reset values; ss_n=1 immediately
//   next cycle, partial frame abandoned, no rsp_valid emitted.
//  rst and cmd_valid same cycle: rst wins, command dropped.
//  Latency (G=GAP_CYCLES, W=RD_WAIT): write rsp at cycle 22+G+1; read rsp at 30+G+W+1.
// TESTING
//  Reset: hold rst 3 cycles mid read frame -> ss_n=1, cmd_ready=1, no rsp_valid afterwards.
//  Write addr 8'hA5 data 8'h3C (G=1) -> ss_n low 1-11 MOSI 0,0,0,1,0,1,0,0,1,0,1;
//   high 12; low 13-23 carrying 0,0,1,0,0,1,1,1,1,0,0; rsp_valid at 24, cmd_ready at 25.
//  Read addr 8'h0F, MISO model returns 8'hC3 (G=1,W=2) -> RD_ADDR 10'h20F, RD_DATA 10'h300,
//   MISO sampled cycles 26-33, rsp_valid at 34 with rsp_rdata=8'hC3, cmd_ready at 35.
//  Back-to-back: write then read with cmd_valid held high -> second accepted only when
//   cmd_ready=1, >=G ss_n-high cycles between ops, write rsp_rdata=8'h00.
//  cmd_valid toggled with random fields during a write -> frames unchanged, one rsp only.
//  End-to-end with spi_wrapper: write 16 random addr/data pairs, read back -> all match.

Source files
------------

// File: rtl/spi_ram_master_if.sv
// Host-side command/response bundle of the SPI RAM transaction controller.
// The master modport is the host; the controller attaches to the slave modport.
interface spi_ram_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_ram_master.sv
// Turns one host write/read command into the address + data SPI frames of the
// slave/RAM wrapper, then captures the serial read-back and returns a response.
module spi_ram_master #(
  parameter int GAP_CYCLES = 1,
  parameter int RD_WAIT    = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_ram_master_if.slave     host,
  output logic                ss_n,
  output logic                MOSI,
  input  logic                MISO
);

  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_WAIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_FRM,
    ST_GAP1,
    ST_DATA_FRM,
    ST_RD_WAIT,
    ST_RD_SHIFT,
    ST_GAP2
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          bit_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                cmd_rw_q;
  logic [7:0]          addr_q;
  logic [7:0]          wdata_q;
  logic [7:0]          rx_shift;
  logic [7:0]          rsp_rdata_q;
  logic [9:0]          frame_word;

  // A frame is the slave's command-check bit (W[9]) followed by W[9..0].
  function automatic logic frame_bit(input logic [9:0] w, input logic [3:0] cnt);
    if (cnt == 4'd0)
      return w[9];
    else if (cnt > 4'd10)
      return 1'b0;
    else
      return w[4'd10 - cnt];
  endfunction

  always_comb begin
    if (state == ST_ADDR_FRM)
      frame_word = {cmd_rw_q, 1'b0, addr_q};
    else if (cmd_rw_q)
      frame_word = 10'h300;
    else
      frame_word = {2'b01, wdata_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      wait_cnt    <= '0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state <= state_nxt;
      // Every state change restarts all counters, so none can pass its terminal count.
      if (state_nxt != state) begin
        bit_cnt  <= '0;
        gap_cnt  <= '0;
        wait_cnt <= '0;
      end else begin
        case (state)
          ST_ADDR_FRM, ST_DATA_FRM, ST_RD_SHIFT: bit_cnt  <= bit_cnt + 4'd1;
          ST_GAP1, ST_GAP2:                      gap_cnt  <= gap_cnt + GAP_W'(1);
          ST_RD_WAIT:                            wait_cnt <= wait_cnt + WAIT_W'(1);
          default: ;
        endcase
      end
      if (state == ST_RD_SHIFT && bit_cnt == 4'd7)
        rsp_rdata_q <= {rx_shift[6:0], MISO};
      else if (state == ST_DATA_FRM && bit_cnt == 4'd10 && !cmd_rw_q)
        rsp_rdata_q <= 8'h00;
    end
  end

  // Command fields and receive shifter carry data only; no reset needed.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && host.cmd_valid) begin
      cmd_rw_q <= host.cmd_rw;
      addr_q   <= host.cmd_addr;
      wdata_q  <= host.cmd_wdata;
    end
    if (state == ST_RD_SHIFT)
      rx_shift <= {rx_shift[6:0], MISO};
  end

  always_comb begin
    state_nxt      = state;
    ss_n           = 1'b1;
    MOSI           = 1'b0;
    host.cmd_ready = 1'b0;
    host.rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        host.cmd_ready = 1'b1;
        if (host.cmd_valid) state_nxt = ST_ADDR_FRM;
      end
      ST_ADDR_FRM: begin
        ss_n = 1'b0;
        MOSI = frame_bit(frame_word, bit_cnt);
        if (bit_cnt == 4'd10) state_nxt = ST_GAP1;
      end
      ST_GAP1: begin
        if (gap_cnt == GAP_LAST) state_nxt = ST_DATA_FRM;
      end
      ST_DATA_FRM: begin
        ss_n = 1'b0;
        MOSI = frame_bit(frame_word, bit_cnt);
        if (bit_cnt == 4'd10) state_nxt = cmd_rw_q ? ST_RD_WAIT : ST_GAP2;
      end
      ST_RD_WAIT: begin
        ss_n = 1'b0;
        if (wait_cnt == WAIT_LAST) state_nxt = ST_RD_SHIFT;
      end
      ST_RD_SHIFT: begin
        ss_n = 1'b0;
        if (bit_cnt == 4'd7) state_nxt = ST_GAP2;
      end
      ST_GAP2: begin
        host.rsp_valid = (gap_cnt == '0);
        if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign host.busy      = (state != ST_IDLE);
  assign host.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: behavioural SPI slave + RAM model on the pins,
// directed pin traces, a vector table and a response scoreboard.
module tb_spi_ram_master;
  localparam int G      = 1;
  localparam int W      = 2;
  localparam int LAT_WR = 22 + G + 1;
  localparam int LAT_RD = 30 + G + W + 1;

  logic clk = 1'b0;
  logic rst;
  logic ss_n, MOSI, miso_d;
  int   cyc = 0;

  spi_ram_master_if hif ();

  spi_ram_master #(.GAP_CYCLES(G), .RD_WAIT(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (hif),
    .ss_n (ss_n),
    .MOSI (MOSI),
    .MISO (miso_d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave + RAM model: 11-bit frames (check bit + word), read data after W wait cycles.
  logic [9:0]  s_sh;
  int          s_cnt = 0;
  bit          s_rd = 1'b0;
  logic [7:0]  s_addr;
  logic [7:0]  mem [256];
  logic [10:0] word_got_q [$];
  logic [10:0] s_full;
  logic [2:0]  s_idx;

  assign s_full = {s_sh, MOSI};
  assign s_idx  = 3'(18 + W - s_cnt);

  always @(posedge clk) begin
    if (ss_n) begin
      s_cnt <= 0;
      s_rd  <= 1'b0;
    end else begin
      s_cnt <= s_cnt + 1;
      if (s_cnt < 10) s_sh <= {s_sh[8:0], MOSI};
      if (s_cnt == 10) begin
        word_got_q.push_back(s_full);
        case (s_full[9:8])
          2'b00, 2'b10: s_addr <= s_full[7:0];
          2'b01:        mem[s_addr] <= s_full[7:0];
          default:      s_rd <= 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    miso_d = 1'b0;
    if (s_rd && s_cnt >= 11 + W && s_cnt <= 18 + W) miso_d = mem[s_addr][s_idx];
  end

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] rsp_exp_q [$];
  logic [7:0] ref_mem [256];

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_words(input logic [9:0] w1, input logic [9:0] w2);
    logic [10:0] g;
    if (word_got_q.size() < 2) begin
      check(1'b0, "frame_count", word_got_q.size(), 2);
      word_got_q.delete();
      return;
    end
    g = word_got_q.pop_front();
    check(g === {w1[9], w1}, "frame1_word", g, {w1[9], w1});
    g = word_got_q.pop_front();
    check(g === {w2[9], w2}, "frame2_word", g, {w2[9], w2});
  endtask

  // Called and returns at a negedge; returns when cmd_ready is back.
  task automatic run_cmd(input logic rw, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input bit hold, input bit trace,
                         input logic [10:0] s1, input logic [10:0] s2,
                         output int c_e, output int rsp_abs);
    int t, n;
    logic [9:0] w1, w2;
    logic [1:0] ep;
    logic [7:0] e;
    w1 = rw ? {2'b10, a} : {2'b00, a};
    w2 = rw ? 10'h300 : {2'b01, d};
    if (!rw) ref_mem[a] = d;
    rsp_exp_q.push_back(exp_rd);
    c_e = 0;
    rsp_abs = 0;
    hif.cmd_rw = rw; hif.cmd_addr = a; hif.cmd_wdata = d; hif.cmd_valid = 1'b1;
    t = 0;
    while (!hif.cmd_ready && t < 400) begin @(negedge clk); t++; end
    if (!hif.cmd_ready) begin
      check(1'b0, "accept_timeout", 0, 1);
      hif.cmd_valid = 1'b0;
      void'(rsp_exp_q.pop_front());
      return;
    end
    @(posedge clk); #1;
    c_e = cyc;
    if (!hold) hif.cmd_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      n = cyc - c_e + 1;
      if (!hif.rsp_valid && trace) begin
        if (n <= 11)          ep = {1'b0, s1[11 - n]};
        else if (n <= 11 + G) ep = 2'b10;
        else if (n <= 22 + G) ep = {1'b0, s2[22 + G - n]};
        else                  ep = 2'b00;
        check({ss_n, MOSI} === ep, $sformatf("pins_cycle%0d", n), {ss_n, MOSI}, ep);
      end
    end while (!hif.rsp_valid && t < 200);
    e = rsp_exp_q.pop_front();
    if (!hif.rsp_valid) begin
      check(1'b0, "rsp_timeout", 0, 1);
      return;
    end
    rsp_abs = cyc;
    check(n == (rw ? LAT_RD : LAT_WR), "rsp_latency", n, rw ? LAT_RD : LAT_WR);
    check(hif.rsp_rdata === e, "rsp_rdata", hif.rsp_rdata, e);
    check(ss_n === 1'b1, "ss_n_at_rsp", ss_n, 1);
    repeat (G) @(negedge clk);
    check(hif.cmd_ready === 1'b1 && hif.busy === 1'b0, "ready_after_gap2",
          {hif.cmd_ready, hif.busy}, 2'b10);
    check_words(w1, w2);
  endtask

  initial begin
    int ce, ra, ce2, ra2, t, bad;
    logic [7:0] rnd_a [16];
    logic [7:0] rnd_d [16];
    logic [7:0] e;

    tbl[0] = '{1'b0, 8'h00, 8'h11, 8'h00};
    tbl[1] = '{1'b0, 8'hFF, 8'hEE, 8'h00};
    tbl[2] = '{1'b0, 8'h80, 8'h01, 8'h00};
    tbl[3] = '{1'b0, 8'h7F, 8'hFE, 8'h00};
    tbl[4] = '{1'b1, 8'h00, 8'h00, 8'h11};
    tbl[5] = '{1'b1, 8'hFF, 8'h00, 8'hEE};
    tbl[6] = '{1'b1, 8'h80, 8'h00, 8'h01};
    tbl[7] = '{1'b1, 8'h7F, 8'h00, 8'hFE};
    tbl[8] = '{1'b0, 8'hFF, 8'h5A, 8'h00};
    tbl[9] = '{1'b1, 8'hFF, 8'h00, 8'h5A};
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    rst = 1'b1;
    hif.cmd_valid = 1'b0; hif.cmd_rw = 1'b0; hif.cmd_addr = 8'h00; hif.cmd_wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check({ss_n, MOSI, hif.cmd_ready, hif.busy, hif.rsp_valid} === 5'b10100, "reset_pins",
          {ss_n, MOSI, hif.cmd_ready, hif.busy, hif.rsp_valid}, 5'b10100);
    check(hif.rsp_rdata === 8'h00, "reset_rdata", hif.rsp_rdata, 8'h00);

    run_cmd(1'b0, 8'hA5, 8'h3C, 8'h00, 1'b0, 1'b1, 11'b00010100101, 11'b00100111100, ce, ra);
    run_cmd(1'b0, 8'h0F, 8'hC3, 8'h00, 1'b0, 1'b0, 11'b0, 11'b0, ce, ra);
    run_cmd(1'b1, 8'h0F, 8'h00, 8'hC3, 1'b0, 1'b1, 11'b11000001111, 11'b11100000000, ce, ra);

    for (int i = 0; i < 10; i++)
      run_cmd(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 1'b0, 1'b0, 11'b0, 11'b0, ce, ra);

    // Reset held three cycles in the middle of the read-data shift.
    hif.cmd_rw = 1'b1; hif.cmd_addr = 8'h0F; hif.cmd_valid = 1'b1;
    @(posedge clk); #1;
    hif.cmd_valid = 1'b0;
    repeat (27) @(negedge clk);
    check(ss_n === 1'b0, "midread_ss_low", ss_n, 0);
    rst = 1'b1;
    @(negedge clk);
    check({ss_n, MOSI, hif.cmd_ready, hif.busy} === 4'b1010, "midread_reset_pins",
          {ss_n, MOSI, hif.cmd_ready, hif.busy}, 4'b1010);
    check(hif.rsp_rdata === 8'h00, "midread_reset_rdata", hif.rsp_rdata, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (hif.rsp_valid || !ss_n) bad++;
    end
    check(bad == 0, "no_activity_after_reset", bad, 0);
    word_got_q.delete();

    // Back-to-back with cmd_valid held high across the write.
    run_cmd(1'b0, 8'h42, 8'h99, 8'h00, 1'b1, 1'b0, 11'b0, 11'b0, ce, ra);
    run_cmd(1'b1, 8'h42, 8'h00, 8'h99, 1'b0, 1'b0, 11'b0, 11'b0, ce2, ra2);
    check(ce2 - ra == G + 1, "b2b_accept_spacing", ce2 - ra, G + 1);

    // Random cmd_valid/field activity while a write is in flight.
    hif.cmd_rw = 1'b0; hif.cmd_addr = 8'h33; hif.cmd_wdata = 8'h77; hif.cmd_valid = 1'b1;
    ref_mem[8'h33] = 8'h77;
    rsp_exp_q.push_back(8'h00);
    @(posedge clk); #1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (!hif.rsp_valid) begin
        hif.cmd_valid = 1'($urandom_range(1, 0));
        hif.cmd_rw    = 1'($urandom_range(1, 0));
        hif.cmd_addr  = 8'($urandom_range(255, 0));
        hif.cmd_wdata = 8'($urandom_range(255, 0));
      end
    end while (!hif.rsp_valid && t < 100);
    hif.cmd_valid = 1'b0;
    e = rsp_exp_q.pop_front();
    check(hif.rsp_valid === 1'b1 && t == LAT_WR, "toggle_rsp_cycle", t, LAT_WR);
    check(hif.rsp_rdata === e, "toggle_rsp_rdata", hif.rsp_rdata, e);
    check_words({2'b00, 8'h33}, {2'b01, 8'h77});
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (hif.rsp_valid || !ss_n) bad++;
    end
    check(bad == 0, "toggle_single_rsp", bad, 0);

    // rst and cmd_valid in the same cycle: command dropped.
    rst = 1'b1; hif.cmd_valid = 1'b1; hif.cmd_rw = 1'b0; hif.cmd_addr = 8'h01; hif.cmd_wdata = 8'h02;
    @(negedge clk);
    rst = 1'b0; hif.cmd_valid = 1'b0;
    check(hif.cmd_ready === 1'b1 && hif.busy === 1'b0, "rst_wins_ready", {hif.cmd_ready, hif.busy}, 2'b10);
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (!ss_n || hif.busy) bad++;
    end
    check(bad == 0, "rst_wins_no_frame", bad, 0);
    check(word_got_q.size() == 0, "rst_wins_no_words", word_got_q.size(), 0);

    // End-to-end: 16 random writes then read-back through the scoreboard.
    for (int i = 0; i < 16; i++) begin
      rnd_a[i] = 8'($urandom_range(255, 0));
      rnd_d[i] = 8'($urandom_range(255, 0));
      run_cmd(1'b0, rnd_a[i], rnd_d[i], 8'h00, 1'b0, 1'b0, 11'b0, 11'b0, ce, ra);
    end
    for (int i = 0; i < 16; i++)
      run_cmd(1'b1, rnd_a[i], 8'h00, ref_mem[rnd_a[i]], 1'b0, 1'b0, 11'b0, 11'b0, ce, ra);

    check(rsp_exp_q.size() == 0, "scoreboard_empty", rsp_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
